// File: rtl/stopwatch_digit_src_if.sv
// Button pulses in, BCD digits and scan index out, between the stopwatch core and its neighbours.
interface stopwatch_digit_src_if;
   logic       btn_start;
   logic       btn_clear;
   logic       btn_lap;
   logic [3:0] in0;
   logic [3:0] in1;
   logic [3:0] in2;
   logic [3:0] in3;
   logic [1:0] ssd_ctl_en;
   logic       running;
   logic       lap_active;

   // Controller side: issues button pulses and watches the display outputs.
   modport master (
      output btn_start, btn_clear, btn_lap,
      input  in0, in1, in2, in3, ssd_ctl_en, running, lap_active
   );

   // Stopwatch core side.
   modport slave (
      input  btn_start, btn_clear, btn_lap,
      output in0, in1, in2, in3, ssd_ctl_en, running, lap_active
   );
endinterface

// File: rtl/stopwatch_digit_src.sv
// MM:SS stopwatch core: one-second prescaler, BCD time counter, run/pause/clear control with
// lap-hold, and a free-running digit-scan index for the seven-segment scan stage.
module stopwatch_digit_src #(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned SCAN_DIV = 100_000
) (
   input logic                   clk,
   input logic                   rst_n,
   stopwatch_digit_src_if.slave  bus
);

   // Keep counters at least one bit wide so a divider of 1 still elaborates.
   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
   localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StPause = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_d;
   logic [TickW-1:0] r_presc;
   logic [3:0]       r_sec1;
   logic [3:0]       r_sec10;
   logic [3:0]       r_min1;
   logic [3:0]       r_min10;
   logic [15:0]      r_snap;
   logic             r_lap_on;
   logic [ScanW-1:0] r_scan_div;
   logic [1:0]       r_scan_idx;

   logic             w_run;
   logic             w_pause;
   logic             w_tick;
   logic             w_clear;
   logic [15:0]      w_live;
   logic [15:0]      w_disp;

   assign w_run   = (r_state == StRun);
   assign w_pause = (r_state == StPause);
   assign w_tick  = w_run && (r_presc == TickMax);
   // Clear is only honoured while paused, and then overrides a simultaneous start.
   assign w_clear = w_pause && bus.btn_clear;
   assign w_live  = {r_min10, r_min1, r_sec10, r_sec1};

   // Next-state decode for the run/pause/clear controller.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (bus.btn_start) w_state_d = StRun;
         StRun:   if (bus.btn_start) w_state_d = StPause;
         StPause: begin
            if (bus.btn_clear)      w_state_d = StIdle;
            else if (bus.btn_start) w_state_d = StRun;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_d;
   end

   // Prescaler advances only in RUN and holds in PAUSE so a partial second carries over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_clear) begin
         r_presc <= '0;
      end else if (w_run) begin
         r_presc <= w_tick ? '0 : r_presc + TickW'(1);
      end
   end

   // Live time in BCD; each digit rolls over at its own limit and carries to the next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sec1  <= '0;
         r_sec10 <= '0;
         r_min1  <= '0;
         r_min10 <= '0;
      end else if (w_clear) begin
         r_sec1  <= '0;
         r_sec10 <= '0;
         r_min1  <= '0;
         r_min10 <= '0;
      end else if (w_tick) begin
         if (r_sec1 != 4'd9) begin
            r_sec1 <= r_sec1 + 4'd1;
         end else begin
            r_sec1 <= '0;
            if (r_sec10 != 4'd5) begin
               r_sec10 <= r_sec10 + 4'd1;
            end else begin
               r_sec10 <= '0;
               if (r_min1 != 4'd9) begin
                  r_min1 <= r_min1 + 4'd1;
               end else begin
                  r_min1 <= '0;
                  r_min10 <= (r_min10 != 4'd5) ? r_min10 + 4'd1 : 4'd0;
               end
            end
         end
      end
   end

   // Lap-hold: snapshot captures the pre-tick live time; a second press releases the hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lap_on <= 1'b0;
         r_snap   <= '0;
      end else if (w_clear) begin
         r_lap_on <= 1'b0;
         r_snap   <= '0;
      end else if (bus.btn_lap) begin
         if (w_run && !r_lap_on) begin
            r_lap_on <= 1'b1;
            r_snap   <= w_live;
         end else if ((w_run || w_pause) && r_lap_on) begin
            r_lap_on <= 1'b0;
         end
      end
   end

   // Free-running scan divider; the 2-bit index wraps 3 -> 0 on its own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_div <= '0;
         r_scan_idx <= '0;
      end else if (r_scan_div == ScanMax) begin
         r_scan_div <= '0;
         r_scan_idx <= r_scan_idx + 2'd1;
      end else begin
         r_scan_div <= r_scan_div + ScanW'(1);
      end
   end

   // Display source select; both candidates are registers, so outputs stay register-driven.
   always_comb begin
      w_disp = w_live;
      if (r_lap_on) w_disp = r_snap;
   end

   assign bus.in0        = w_disp[15:12];
   assign bus.in1        = w_disp[11:8];
   assign bus.in2        = w_disp[7:4];
   assign bus.in3        = w_disp[3:0];
   assign bus.ssd_ctl_en = r_scan_idx;
   assign bus.running    = w_run;
   assign bus.lap_active = r_lap_on;

endmodule

// File: tb/tb_stopwatch_digit_src.sv
// Bench for stopwatch_digit_src: three instances with small dividers, a seconds-based reference
// model, a hand-written vector table, directed corner sequences and a random phase.
module tb_stopwatch_digit_src;

   localparam int TdA = 4;
   localparam int SdA = 3;
   localparam int TdB = 1;
   localparam int SdB = 1;
   localparam int TdC = 2;
   localparam int SdC = 3;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MPause = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Button vectors are {lap, clear, start}.
   logic [2:0] btn_a = 3'b000;
   logic [2:0] btn_b = 3'b000;
   logic [2:0] btn_c = 3'b000;

   stopwatch_digit_src_if if_a ();
   stopwatch_digit_src_if if_b ();
   stopwatch_digit_src_if if_c ();

   assign if_a.btn_start = btn_a[0];
   assign if_a.btn_clear = btn_a[1];
   assign if_a.btn_lap   = btn_a[2];
   assign if_b.btn_start = btn_b[0];
   assign if_b.btn_clear = btn_b[1];
   assign if_b.btn_lap   = btn_b[2];
   assign if_c.btn_start = btn_c[0];
   assign if_c.btn_clear = btn_c[1];
   assign if_c.btn_lap   = btn_c[2];

   stopwatch_digit_src #(.TICK_DIV(TdA), .SCAN_DIV(SdA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   stopwatch_digit_src #(.TICK_DIV(TdB), .SCAN_DIV(SdB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   stopwatch_digit_src #(.TICK_DIV(TdC), .SCAN_DIV(SdC)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   // Observation vector: {in0, in1, in2, in3, ssd_ctl_en, running, lap_active}.
   logic [19:0] obs_a;
   logic [19:0] obs_b;
   logic [19:0] obs_c;
   assign obs_a = {if_a.in0, if_a.in1, if_a.in2, if_a.in3, if_a.ssd_ctl_en, if_a.running,
                   if_a.lap_active};
   assign obs_b = {if_b.in0, if_b.in1, if_b.in2, if_b.in3, if_b.ssd_ctl_en, if_b.running,
                   if_b.lap_active};
   assign obs_c = {if_c.in0, if_c.in1, if_c.in2, if_c.in3, if_c.ssd_ctl_en, if_c.running,
                   if_c.lap_active};

   // Model keeps time as a plain count of seconds; digits are derived only for comparison.
   typedef struct {
      int st;
      int secs;
      int presc;
      bit lap;
      int snap;
      int sdiv;
      int sidx;
   } model_t;

   typedef struct {
      logic [2:0] bc;
      logic [2:0] ba;
      int         disp;
      logic       run;
      logic       lap;
   } vec_t;

   model_t ma, mb, mc;
   vec_t   vec [28];
   int     checks = 0;
   int     errors = 0;

   function automatic logic [15:0] to_bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic model_t model_step(input model_t m, input logic [2:0] b, input int tdiv,
                                         input int sdiv);
      model_t n;
      bit     tick;
      n    = m;
      tick = (m.st == MRun) && (m.presc == tdiv - 1);
      if (m.st == MRun) n.presc = tick ? 0 : m.presc + 1;
      if (tick) n.secs = (m.secs + 1) % 3600;
      if (b[2]) begin
         if (m.st == MRun && !m.lap) begin
            n.lap  = 1'b1;
            n.snap = m.secs;
         end else if (m.st != MIdle && m.lap) begin
            n.lap = 1'b0;
         end
      end
      case (m.st)
         MIdle: if (b[0]) n.st = MRun;
         MRun:  if (b[0]) n.st = MPause;
         default: begin
            if (b[1]) begin
               n.st    = MIdle;
               n.secs  = 0;
               n.presc = 0;
               n.lap   = 1'b0;
            end else if (b[0]) begin
               n.st = MRun;
            end
         end
      endcase
      if (m.sdiv == sdiv - 1) begin
         n.sdiv = 0;
         n.sidx = (m.sidx + 1) % 4;
      end else begin
         n.sdiv = m.sdiv + 1;
      end
      return n;
   endfunction

   function automatic logic [19:0] model_obs(input model_t m);
      int d;
      d = m.lap ? m.snap : m.secs;
      return {to_bcd(d), 2'(m.sidx), (m.st == MRun), m.lap};
   endfunction

   task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      ma = '{default: 0};
      mb = '{default: 0};
      mc = '{default: 0};
   endtask

   // One clock: present buttons, let the edge happen, advance models, compare all instances.
   task automatic step(input logic [2:0] ba, input logic [2:0] bb, input logic [2:0] bc);
      btn_a = ba;
      btn_b = bb;
      btn_c = bc;
      @(posedge clk);
      ma = model_step(ma, ba, TdA, SdA);
      mb = model_step(mb, bb, TdB, SdB);
      mc = model_step(mc, bc, TdC, SdC);
      #1;
      btn_a = 3'b000;
      btn_b = 3'b000;
      btn_c = 3'b000;
      chk("model_a", obs_a, model_obs(ma));
      chk("model_b", obs_b, model_obs(mb));
      chk("model_c", obs_c, model_obs(mc));
   endtask

   // Asynchronous reset between edges; outputs must clear without waiting for a clock.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_a"}, obs_a, 20'h0);
      chk({tag, "_b"}, obs_b, 20'h0);
      chk({tag, "_c"}, obs_c, 20'h0);
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      // Instance C lap/pause/clear walk (TICK_DIV=2); instance A gets start/pause/clear pulses
      // while its scan index is checked against the 0,1,2,3,0 pattern.
      vec[0]  = '{3'b001, 3'b000, 0, 1'b1, 1'b0};
      vec[1]  = '{3'b000, 3'b001, 0, 1'b1, 1'b0};
      vec[2]  = '{3'b000, 3'b000, 1, 1'b1, 1'b0};
      vec[3]  = '{3'b000, 3'b000, 1, 1'b1, 1'b0};
      vec[4]  = '{3'b000, 3'b001, 2, 1'b1, 1'b0};
      vec[5]  = '{3'b000, 3'b000, 2, 1'b1, 1'b0};
      vec[6]  = '{3'b000, 3'b000, 3, 1'b1, 1'b0};
      vec[7]  = '{3'b000, 3'b010, 3, 1'b1, 1'b0};
      vec[8]  = '{3'b100, 3'b000, 3, 1'b1, 1'b1};   // lap with tick: freezes pre-tick 00:03
      vec[9]  = '{3'b000, 3'b000, 3, 1'b1, 1'b1};
      vec[10] = '{3'b000, 3'b000, 3, 1'b1, 1'b1};
      vec[11] = '{3'b010, 3'b000, 3, 1'b1, 1'b1};   // clear in RUN ignored
      vec[12] = '{3'b000, 3'b000, 3, 1'b1, 1'b1};
      vec[13] = '{3'b100, 3'b000, 6, 1'b1, 1'b0};   // release shows live 00:06
      vec[14] = '{3'b001, 3'b000, 7, 1'b0, 1'b0};   // pause with tick: increment kept
      vec[15] = '{3'b100, 3'b000, 7, 1'b0, 1'b0};   // lap in PAUSE with hold off ignored
      vec[16] = '{3'b000, 3'b000, 7, 1'b0, 1'b0};
      vec[17] = '{3'b001, 3'b000, 7, 1'b1, 1'b0};
      vec[18] = '{3'b000, 3'b000, 7, 1'b1, 1'b0};
      vec[19] = '{3'b100, 3'b000, 7, 1'b1, 1'b1};
      vec[20] = '{3'b001, 3'b000, 7, 1'b0, 1'b1};
      vec[21] = '{3'b100, 3'b000, 8, 1'b0, 1'b0};   // hold released while paused
      vec[22] = '{3'b011, 3'b000, 0, 1'b0, 1'b0};   // clear beats start
      vec[23] = '{3'b100, 3'b000, 0, 1'b0, 1'b0};
      vec[24] = '{3'b010, 3'b000, 0, 1'b0, 1'b0};
      vec[25] = '{3'b001, 3'b000, 0, 1'b1, 1'b0};
      vec[26] = '{3'b000, 3'b000, 0, 1'b1, 1'b0};
      vec[27] = '{3'b000, 3'b000, 1, 1'b1, 1'b0};   // prescaler was zeroed by the clear

      model_reset();
      #2;
      chk("por_a", obs_a, 20'h0);
      chk("por_b", obs_b, 20'h0);
      chk("por_c", obs_c, 20'h0);
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         step(vec[i].ba, 3'b000, vec[i].bc);
         chk($sformatf("tbl%0d_disp", i), 20'(obs_c[19:4]), 20'(to_bcd(vec[i].disp)));
         chk($sformatf("tbl%0d_flags", i), 20'(obs_c[1:0]), 20'({vec[i].run, vec[i].lap}));
         chk($sformatf("tbl%0d_scan", i), 20'(obs_a[3:2]), 20'(((i + 1) / 3) % 4));
      end

      // Pause after two RUN cycles, idle, resume: the tick lands two cycles after resuming.
      do_reset("rst1");
      step(3'b001, 3'b000, 3'b000);
      step(3'b000, 3'b000, 3'b000);
      step(3'b001, 3'b000, 3'b000);
      repeat (10) step(3'b000, 3'b000, 3'b000);
      step(3'b001, 3'b000, 3'b000);
      chk("resume_r0", 20'(obs_a[7:4]), 20'd0);
      step(3'b000, 3'b000, 3'b000);
      chk("resume_r1", 20'(obs_a[7:4]), 20'd0);
      step(3'b000, 3'b000, 3'b000);
      chk("resume_r2", 20'(obs_a[7:4]), 20'd1);

      // Counting with a tick every cycle through 01:00 and the 59:59 rollover.
      do_reset("rst2");
      step(3'b000, 3'b001, 3'b000);
      repeat (60) step(3'b000, 3'b000, 3'b000);
      chk("count_0100", 20'(obs_b[19:4]), 20'h0100);
      repeat (3540) step(3'b000, 3'b000, 3'b000);
      chk("wrap_0000", 20'(obs_b[19:4]), 20'h0000);
      chk("wrap_running", 20'(obs_b[1]), 20'd1);

      // Reset in the middle of a run at 00:07.
      do_reset("rst3");
      step(3'b001, 3'b000, 3'b000);
      repeat (28) step(3'b000, 3'b000, 3'b000);
      chk("mid_0007", 20'(obs_a[19:4]), 20'h0007);
      chk("mid_running", 20'(obs_a[1]), 20'd1);
      do_reset("midrst");

      // Random sparse button traffic on all instances.
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] ra, rb, rc;
         ra = {($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0)};
         rb = {($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0)};
         rc = {($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0)};
         step(ra, rb, rc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
